msrh_l1d_rd_arbiter: RTL
========================

Name: msrh_l1d_rd_arbiter

Overview:
- Shares one L1D read port between REQ_NUM requesters, such as PTW access, snoop, LRQ refill-read and STQ read.
- Arbitrates in s0 and forwards the winner's paddr to the dcache read port.
- Tracks the grant into s1 and routes hit/miss/conflict/data back to the granted requester.
- Uses round-robin priority with starvation promotion; it sits between the requesters and msrh_dcache.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- PADDR_W, riscv_pkg::PADDR_W, physical address width.
- DATA_W, msrh_conf_pkg::DCACHE_DATA_W, cache line read width.
- STARVE_TH, 8, consecutive denied cycles before a requester is promoted (>=1).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  async active-low reset
- i_req_valid  in  REQ_NUM  s0 request per requester
- i_req_paddr  in  REQ_NUM x PADDR_W  s0 address per requester
- o_req_ready  out  REQ_NUM  s0 grant, one-hot or zero
- i_port_stall  in  1  dcache port unavailable this cycle (write/refill priority)
- o_s0_valid  out  1  to dcache read port
- o_s0_paddr  out  PADDR_W  to dcache read port
- i_s1_hit  in  1  from dcache s1
- i_s1_miss  in  1  from dcache s1
- i_s1_conflict  in  1  from dcache s1
- i_s1_data  in  DATA_W  from dcache s1
- o_resp_valid  out  REQ_NUM  s1 response strobe, one-hot
- o_resp_status  out  lsu_status_t  STATUS_HIT / STATUS_L1D_CONFLICT / STATUS_MISS / STATUS_NONE
- o_resp_data  out  DATA_W  broadcast i_s1_data

Behaviour:
- Reset: async, active-low; clock i_clk. Clears r_rr_ptr=0, all r_age=0 and r_s1_grant_oh=0. Hence o_resp_valid=0. o_req_ready and o_s0_valid are 0 at reset because there are no requests.
- Handshake: a requester holds valid and paddr until ready=1 in the same cycle.
  - Dropping valid before a grant is legal; it clears that requester's age.
  - The grant is combinational from i_req_valid, r_age, r_rr_ptr and i_port_stall.
- Grant selection:
  - If i_port_stall=1, no grant: o_req_ready=0 and o_s0_valid=0.
  - Otherwise, if any valid requester has r_age==STARVE_TH, the lowest-index such requester wins.
  - Otherwise round-robin: the first valid requester scanning from r_rr_ptr upward, with wrap REQ_NUM-1 -> 0.
- Datapath: o_s0_valid = |grant. o_s0_paddr = the granted requester's paddr, or 0 when no grant.
- r_rr_ptr update: on a grant to index g, r_rr_ptr <= (g==REQ_NUM-1) ? 0 : g+1. Otherwise it holds.
- r_age[i] update, width $clog2(STARVE_TH+1):
  - Cleared when granted or when not valid.
  - Otherwise increments, saturating at STARVE_TH.
  - Stall cycles also increment.
- s1 latency is exactly 1 cycle: r_s1_grant_oh <= grant. o_resp_valid = r_s1_grant_oh.
- o_resp_status priority: hit > conflict > miss > NONE.
- A requester that dropped valid after its grant still receives its s1 response; it is not cancelled.
- Back-to-back: the same requester may win on consecutive cycles only if no other requester is valid.
- Simultaneous starvation of several requesters: the lowest index wins. The others keep saturating and are served on following cycles.
- SIMULATION checks ($fatal):
  - more than one bit set in the grant;
  - i_s1_hit & i_s1_miss both asserted.

Optional Feature:
- MSRH_L1D_RD_ARB_PERF_EN defined:
  - Adds output o_perf_grant_cnt (REQ_NUM x 32): saturating per-requester grant counters.
  - Adds output o_perf_starve_cnt (32): saturating count of starvation-promoted grants.
  - All counters reset to 0.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- msrh_lsu_pkg: reuse lsu_status_t. Add typedef l1d_rd_arb_req_t {valid, paddr}. Add constant L1D_RD_ARB_STARVE_TH=8.
- One natural sub-module: msrh_rr_age_picker. It takes valid, age and pointer, and produces the grant one-hot plus the next pointer. It is pure combinational plus pointer/age flops, and is reusable for the L2 request arbiter.

Test Plan:
- Single requester: req1 valid, paddr 0x8000_0040.
  - Cycle 0: ready[1]=1, o_s0_paddr=0x8000_0040.
  - Cycle 1: i_s1_hit=1 -> o_resp_valid=0b0010, status HIT.
- Round-robin: all 4 valid continuously, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, and no age reaches STARVE_TH.
- Stall: all valid, i_port_stall=1 for 8 cycles -> no grants, all ages=8.
  - On release, grants follow lowest-index-starved order 0,1,2,3, independent of rr_ptr.
- Starvation, with STARVE_TH=2 and req0 at rr_ptr=1 vs continuously valid req1 and req2:
  - Cycle 0: req1 wins; req0 and req2 ages reach 1.
  - Cycle 1: req2 wins; req0 age reaches 2, the threshold.
  - Cycle 2: req0 wins by promotion.
- Response status:
  - grant req3, then i_s1_conflict=1 -> resp_valid=0b1000, status L1D_CONFLICT;
  - grant req2, then miss only -> status MISS.
- Reset mid-operation: grant issued, reset asserted before s1 -> o_resp_valid=0 immediately, rr_ptr=0. The next request from req2 is granted normally.

Source files
------------

// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types and constants used by the L1D read-port arbiter and its picker.
package msrh_lsu_pkg;

  localparam int L1D_PADDR_W          = 40;
  localparam int L1D_DATA_W           = 64;
  localparam int L1D_RD_ARB_STARVE_TH = 8;

  typedef enum logic [1:0] {
    STATUS_NONE,
    STATUS_HIT,
    STATUS_MISS,
    STATUS_L1D_CONFLICT
  } lsu_status_t;

  typedef struct packed {
    logic                   valid;
    logic [L1D_PADDR_W-1:0] paddr;
  } l1d_rd_arb_req_t;

endpackage

// File: rtl/msrh_rr_age_picker.sv
// Round-robin one-hot picker with per-requester age counters; a requester whose
// age reaches STARVE_TH is promoted ahead of the round-robin order.
module msrh_rr_age_picker #(
  parameter int REQ_NUM   = 4,
  parameter int STARVE_TH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [REQ_NUM-1:0] valid,
  input  logic               stall,
  output logic [REQ_NUM-1:0] grant,
  output logic               promoted
);

  localparam int AGE_W = $clog2(STARVE_TH + 1);
  localparam int PTR_W = $clog2(REQ_NUM);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [AGE_W-1:0]   age [REQ_NUM];
  logic [REQ_NUM-1:0] starved;
  logic               found;

  always_comb begin
    grant    = '0;
    promoted = 1'b0;
    found    = 1'b0;
    next_ptr = rr_ptr;
    for (int i = 0; i < REQ_NUM; i++) begin
      starved[i] = valid[i] && (age[i] == AGE_W'(STARVE_TH));
    end
    if (!stall) begin
      if (|starved) begin
        promoted = 1'b1;
        for (int i = 0; i < REQ_NUM; i++) begin
          if (!found && starved[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end else begin
        // Scan offsets from the pointer so the first valid one after it wins.
        for (int k = 0; k < REQ_NUM; k++) begin
          for (int i = 0; i < REQ_NUM; i++) begin
            if (!found && valid[i] && (((int'(rr_ptr) + k) % REQ_NUM) == i)) begin
              grant[i] = 1'b1;
              found    = 1'b1;
            end
          end
        end
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        next_ptr = (i == REQ_NUM - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        age[i] <= '0;
      end
    end else begin
      rr_ptr <= next_ptr;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (grant[i] || !valid[i]) begin
          age[i] <= '0;
        end else if (age[i] != AGE_W'(STARVE_TH)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/msrh_l1d_rd_arbiter.sv
// Shares the L1D read port among REQ_NUM requesters and routes s1 results back.
// Optional perf counters are built when MSRH_L1D_RD_ARB_PERF_EN is defined.
module msrh_l1d_rd_arbiter
  import msrh_lsu_pkg::*;
#(
  parameter int REQ_NUM   = 4,
  parameter int PADDR_W   = L1D_PADDR_W,
  parameter int DATA_W    = L1D_DATA_W,
  parameter int STARVE_TH = L1D_RD_ARB_STARVE_TH
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [REQ_NUM-1:0]         i_req_valid,
  input  logic [REQ_NUM*PADDR_W-1:0] i_req_paddr,
  output logic [REQ_NUM-1:0]         o_req_ready,
  input  logic                       i_port_stall,
  output logic                       o_s0_valid,
  output logic [PADDR_W-1:0]         o_s0_paddr,
  input  logic                       i_s1_hit,
  input  logic                       i_s1_miss,
  input  logic                       i_s1_conflict,
  input  logic [DATA_W-1:0]          i_s1_data,
  output logic [REQ_NUM-1:0]         o_resp_valid,
  output lsu_status_t                o_resp_status,
  output logic [DATA_W-1:0]          o_resp_data
`ifdef MSRH_L1D_RD_ARB_PERF_EN
  ,
  output logic [REQ_NUM*32-1:0]      o_perf_grant_cnt,
  output logic [31:0]                o_perf_starve_cnt
`endif
);

  logic [REQ_NUM-1:0] grant;
  logic               promoted;
  logic [REQ_NUM-1:0] s1_grant_oh;

  msrh_rr_age_picker #(
    .REQ_NUM  (REQ_NUM),
    .STARVE_TH(STARVE_TH)
  ) u_picker (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .valid   (i_req_valid),
    .stall   (i_port_stall),
    .grant   (grant),
    .promoted(promoted)
  );

  assign o_req_ready = grant;
  assign o_s0_valid  = |grant;

  always_comb begin
    o_s0_paddr = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      o_s0_paddr = o_s0_paddr | ({PADDR_W{grant[i]}} & i_req_paddr[i*PADDR_W +: PADDR_W]);
    end
  end

  // Responses are never cancelled: the grant alone decides who sees s1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_grant_oh <= '0;
    end else begin
      s1_grant_oh <= grant;
    end
  end

  assign o_resp_valid = s1_grant_oh;
  assign o_resp_data  = i_s1_data;

  always_comb begin
    o_resp_status = STATUS_NONE;
    if (i_s1_hit) begin
      o_resp_status = STATUS_HIT;
    end else if (i_s1_conflict) begin
      o_resp_status = STATUS_L1D_CONFLICT;
    end else if (i_s1_miss) begin
      o_resp_status = STATUS_MISS;
    end
  end

`ifdef MSRH_L1D_RD_ARB_PERF_EN
  logic [31:0] grant_cnt [REQ_NUM];
  logic [31:0] starve_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_cnt <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      if (promoted && (starve_cnt != '1)) begin
        starve_cnt <= starve_cnt + 32'd1;
      end
      for (int i = 0; i < REQ_NUM; i++) begin
        if (grant[i] && (grant_cnt[i] != '1)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_perf
    assign o_perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
  end
  assign o_perf_starve_cnt = starve_cnt;
`else
  logic unused_promoted;
  assign unused_promoted = promoted;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert ($onehot0(grant)) else $fatal(1, "l1d_rd_arbiter: grant is not one-hot");
      assert (!(i_s1_hit && i_s1_miss)) else $fatal(1, "l1d_rd_arbiter: s1 hit and miss together");
    end
  end
`endif

endmodule
